// File: rtl/eq_stream_lock.sv
// eq_stream_lock: streaming equality tracker with lock detection.
// Takes a/b operand pairs under valid/ready and registers a per-pair
// equality flag. It declares lock after LOCK_LEN consecutive matches.
// Lock is kept through up to MISS_TOL-1 consecutive mismatches and is
// dropped after MISS_TOL consecutive mismatches.
//
// Handshake contract, on both sides:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A source that raises valid holds its data stable until that transfer.
//   Ready may depend combinationally on the consumer's ready. That is,
//   in_ready = ~out_valid | out_ready. There is a single output register
//   and no skid buffer.
//   A synchronous clr blocks input acceptance on its edge.
module eq_stream_lock #(
  parameter int W        = 2,
  parameter int LOCK_LEN = 4,
  parameter int MISS_TOL = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             locked,
  output logic [CNT_W-1:0] streak,
  output logic [CNT_W-1:0] miss_total,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // The miss-run counter only needs to reach MISS_TOL.
  // It parks at MISS_TOL instead of wrapping.
  localparam int MR_W = (MISS_TOL < 1) ? 1 : $clog2(MISS_TOL + 1);
  localparam logic [MR_W-1:0]  MR_TOL  = MR_W'(MISS_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q;
  logic               out_valid_q;
  logic               out_eq_q;
  logic               locked_q;
  logic [CNT_W-1:0]   streak_q;
  logic [CNT_W-1:0]   miss_total_q;
  logic [MR_W-1:0]    miss_run_q;

  logic               match;
  logic               accept;
  logic [CNT_W-1:0]   streak_d;
  logic [CNT_W-1:0]   miss_total_d;
  logic [MR_W-1:0]    miss_run_d;
  logic               lock_hit;
  logic               drop_hit;

  // Handshake and post-update counter values for the pair offered this cycle.
  always_comb begin
    match    = (a == b);
    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready & ~clr;

    streak_d     = '0;
    miss_total_d = miss_total_q;
    miss_run_d   = '0;
    if (match) begin
      streak_d = (streak_q == CNT_MAX) ? streak_q : streak_q + CNT_W'(1);
    end else begin
      miss_total_d = (miss_total_q == CNT_MAX) ? miss_total_q
                                               : miss_total_q + CNT_W'(1);
      miss_run_d   = (miss_run_q >= MR_TOL) ? miss_run_q
                                            : miss_run_q + MR_W'(1);
    end

    // Lock criteria are evaluated on the post-update counter values.
    lock_hit = match & (32'(streak_d) >= 32'(LOCK_LEN));
    drop_hit = ~match & (miss_run_d >= MR_TOL);
  end

  // Lock FSM, output register and counters. Everything advances only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      out_valid_q  <= 1'b0;
      out_eq_q     <= 1'b0;
      locked_q     <= 1'b0;
      streak_q     <= '0;
      miss_total_q <= '0;
      miss_run_q   <= '0;
    end else if (clr) begin
      state_q      <= SEARCH;
      out_valid_q  <= 1'b0;
      out_eq_q     <= 1'b0;
      locked_q     <= 1'b0;
      streak_q     <= '0;
      miss_total_q <= '0;
      miss_run_q   <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_eq_q     <= match;
      streak_q     <= streak_d;
      miss_total_q <= miss_total_d;
      miss_run_q   <= miss_run_d;
      case (state_q)
        SEARCH: begin
          if (lock_hit) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            locked_q <= 1'b0;
          end
        end
        // The first miss from LOCKED always has a miss run of 1.
        // When MISS_TOL is 1, drop_hit sends it straight to SEARCH.
        LOCKED, HOLD: begin
          if (match) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else if (drop_hit) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end else begin
            state_q  <= HOLD;
            locked_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Drive the output ports from the registers.
  always_comb begin
    out_valid  = out_valid_q;
    out_eq     = out_eq_q;
    locked     = locked_q;
    streak     = streak_q;
    miss_total = miss_total_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_eq_stream_lock.sv
// Bench for eq_stream_lock. The main instance uses the default parameters.
// A second instance uses CNT_W=3 so counter saturation can be reached quickly.
module tb_eq_stream_lock;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       clr;
  logic [1:0] in_a, in_b;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, out_eq, locked;
  logic [7:0] streak, miss_total;
  logic [1:0] state_dbg;

  logic [1:0] s_a, s_b;
  logic       s_valid, s_in_ready, s_out_valid, s_out_eq, s_locked;
  logic [2:0] s_streak, s_miss;
  logic [1:0] s_state;

  eq_stream_lock #(.W(2), .LOCK_LEN(4), .MISS_TOL(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .a(in_a), .b(in_b),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_eq(out_eq), .locked(locked),
    .streak(streak), .miss_total(miss_total), .state_dbg(state_dbg)
  );

  eq_stream_lock #(.W(2), .LOCK_LEN(4), .MISS_TOL(2), .CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .a(s_a), .b(s_b),
    .in_valid(s_valid), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_ready(1'b1), .out_eq(s_out_eq), .locked(s_locked),
    .streak(s_streak), .miss_total(s_miss), .state_dbg(s_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Each entry is {eq, locked, streak[7:0], miss_total[7:0]}.
  logic [17:0] exp_q[$];
  int m_state, m_streak, m_miss, m_run;

  task automatic model_reset();
    m_state = 0; m_streak = 0; m_miss = 0; m_run = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [1:0] pa, input logic [1:0] pb);
    bit m;
    bit lk;
    m = (pa == pb);
    if (m) begin
      m_streak = (m_streak == 255) ? 255 : m_streak + 1;
      m_run = 0;
    end else begin
      m_streak = 0;
      m_miss = (m_miss == 255) ? 255 : m_miss + 1;
      m_run = m_run + 1;
    end
    case (m_state)
      0: if (m && m_streak >= 4) m_state = 1;
      1: if (!m) m_state = (m_run >= 2) ? 0 : 2;
      default: begin
        if (m) m_state = 1;
        else if (m_run >= 2) m_state = 0;
      end
    endcase
    lk = (m_state != 0);
    exp_q.push_back({m, lk, 8'(m_streak), 8'(m_miss)});
  endtask

  // Output monitor. A result is consumed on the edge that follows a
  // negedge where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("out_eq", out_eq, e[17]);
        check("locked", locked, e[16]);
        check("streak", streak, e[15:8]);
        check("miss_total", miss_total, e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] pa, input logic [1:0] pb, input bit rnd_ready);
    bit done;
    done = 0;
    in_a = pa; in_b = pb; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        model_accept(pa, pb);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic check_model_state(input string tag);
    check({tag, "_state"}, state_dbg, m_state);
    check({tag, "_locked"}, locked, (m_state != 0));
  endtask

  // Watchdog: a hung run stops here instead of spinning forever.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [17:0] f;
    logic [1:0] pa, pb;
    reset_n = 1'b0; clr = 1'b0; in_a = '0; in_b = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    s_a = '0; s_b = '0; s_valid = 1'b0;
    model_reset();

    // Outputs are checked while reset is held.
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eq", out_eq, 0);
    check("rst_locked", locked, 0);
    check("rst_streak", streak, 0);
    check("rst_miss", miss_total, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Four matches should acquire lock.
    out_ready = 1'b1;
    repeat (4) send(2'd1, 2'd1, 0);
    drain();
    check_model_state("t1");
    check("t1_state_locked", state_dbg, 1);
    check("t1_streak", streak, 4);

    // A single miss goes to HOLD, and the next match returns to LOCKED.
    send(2'd2, 2'd1, 0);
    send(2'd3, 2'd3, 0);
    drain();
    check_model_state("t2");
    check("t2_streak", streak, 1);
    check("t2_miss", miss_total, 1);

    // Two misses in a row drop lock.
    send(2'd0, 2'd3, 0);
    send(2'd1, 2'd2, 0);
    drain();
    check_model_state("t3");
    check("t3_state_search", state_dbg, 0);
    check("t3_miss", miss_total, 3);

    // Backpressure: one pair is taken, then the block stalls and holds its outputs.
    out_ready = 1'b0;
    send(2'd1, 2'd2, 0);
    f = exp_q[0];
    in_a = 2'd3; in_b = 2'd3; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_eq_frozen", out_eq, f[17]);
      check("bp_streak_frozen", streak, f[15:8]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd3, 2'd3, 0);

    // Random pairs under random consumer backpressure.
    for (int i = 0; i < 20; i++) begin
      pa = 2'($urandom_range(0, 3));
      pb = ($urandom_range(0, 1) == 1) ? pa : 2'($urandom_range(0, 3));
      send(pa, pb, 1);
    end
    drain();
    check_model_state("rand");

    // clr while a result is pending and a new pair is offered.
    repeat (5) send(2'd2, 2'd2, 0);
    drain();
    check("pre_clr_locked", locked, 1);
    out_ready = 1'b0;
    send(2'd0, 2'd0, 0);
    in_a = 2'd1; in_b = 2'd1; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("clr_out_valid", out_valid, 0);
    check("clr_streak", streak, 0);
    check("clr_locked", locked, 0);
    check("clr_miss", miss_total, 0);
    check("clr_state", state_dbg, 0);
    check("clr_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Asynchronous reset asserted mid-cycle, with a result pending.
    out_ready = 1'b1;
    send(2'd2, 2'd2, 0);
    send(2'd1, 2'd1, 0);
    out_ready = 1'b0;
    check("prerst_out_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_eq", out_eq, 0);
    check("arst_locked", locked, 0);
    check("arst_streak", streak, 0);
    check("arst_miss", miss_total, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd1, 2'd1, 0);
    drain();
    check("post_rst_streak", streak, 1);

    // Saturation on the CNT_W=3 instance.
    s_valid = 1'b1; s_a = 2'd1; s_b = 2'd1;
    repeat (10) @(posedge clk);
    #1;
    check("sat_streak", s_streak, 7);
    check("sat_locked", s_locked, 1);
    s_b = 2'd2;
    repeat (10) @(posedge clk);
    #1;
    check("sat_miss", s_miss, 7);
    check("sat_streak_zero", s_streak, 0);
    check("sat_unlocked", s_locked, 0);
    s_valid = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
